// File: rtl/proc_instr_sequencer.sv
// Instruction sequencer: queues host instruction words and issues them one at a time to simple_processor.
// Optional WAIT_DONE watchdog with HALT state and sticky timeout_err, enabled by defining SEQ_TIMEOUT_EN.
module proc_instr_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk_50MHz,
    input  logic                          reset_n,
    input  logic                          in_valid,
    input  logic [15:0]                   in_data,
    output logic                          in_ready,
    input  logic                          seq_enable,
    input  logic                          flush,
    output logic [15:0]                   proc_din,
    output logic                          proc_run,
    input  logic                          proc_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [15:0]                   issued_count,
    output logic                          timeout_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        HALT
    } state_t;

    state_t        state;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          issue;

    assign full     = (fifo_count == CW'(FIFO_DEPTH));
    assign empty    = (fifo_count == '0);
    assign in_ready = !full;

    // flush wins over both a same-cycle push and a same-cycle issue
    assign push  = in_valid && !full && !flush;
    assign issue = (state == IDLE) && seq_enable && !empty && !flush;

    always_ff @(posedge clk_50MHz) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, issue})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] wait_timer;

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            proc_din     <= '0;
            proc_run     <= 1'b0;
            busy         <= 1'b0;
            issued_count <= '0;
            timeout_err  <= 1'b0;
            wait_timer   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state    <= ISSUE;
                        proc_din <= mem[rd_ptr];
                        proc_run <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    state      <= WAIT_DONE;
                    proc_run   <= 1'b0;
                    wait_timer <= '0;
                end
                WAIT_DONE: begin
                    // a timed-out word is abandoned without counting it
                    if (proc_done) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        issued_count <= issued_count + 16'd1;
                    end else if (wait_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        state       <= HALT;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_timer <= wait_timer + TW'(1);
                    end
                end
                HALT: begin
                    if (flush) begin
                        state       <= IDLE;
                        timeout_err <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_err           = 1'b0;

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            proc_din     <= '0;
            proc_run     <= 1'b0;
            busy         <= 1'b0;
            issued_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state    <= ISSUE;
                        proc_din <= mem[rd_ptr];
                        proc_run <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= WAIT_DONE;
                    proc_run <= 1'b0;
                end
                WAIT_DONE: begin
                    if (proc_done) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        issued_count <= issued_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_proc_instr_sequencer.sv
// Directed bench for proc_instr_sequencer: issue order, FIFO full/flush, enable gating, reset, optional timeout.
module tb_proc_instr_sequencer;

    logic        clk_50MHz = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        seq_enable;
    logic        flush;
    logic [15:0] proc_din;
    logic        proc_run;
    logic        proc_done;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [15:0] issued_count;
    logic        timeout_err;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] issue_log [$];
    logic [15:0] words [5];

    proc_instr_sequencer #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .seq_enable   (seq_enable),
        .flush        (flush),
        .proc_din     (proc_din),
        .proc_run     (proc_run),
        .proc_done    (proc_done),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .issued_count (issued_count),
        .timeout_err  (timeout_err)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // every run pulse lasts one full cycle, so each one is logged exactly once here
    always @(negedge clk_50MHz) begin
        if (proc_run === 1'b1) begin
            issue_log.push_back(proc_din);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_50MHz);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] word);
        in_valid = 1'b1;
        in_data  = word;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finishWait(input int lat);
        for (int i = 0; i < lat; i++) begin
            tick();
            checkOutput("no_run_while_waiting", {15'd0, proc_run}, 16'd0);
        end
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
    endtask

    task automatic serve(input int lat);
        bit found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (proc_run === 1'b1) found = 1'b1;
            else tick();
        end
        checkOutput("run_seen", {15'd0, found}, 16'd1);
        tick();
        finishWait(lat);
    endtask

    initial begin
        reset_n    = 1'b0;
        in_valid   = 1'b0;
        in_data    = 16'h0000;
        seq_enable = 1'b0;
        flush      = 1'b0;
        proc_done  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;

        checkOutput("rst_proc_din", proc_din, 16'h0000);
        checkOutput("rst_proc_run", {15'd0, proc_run}, 16'd0);
        checkOutput("rst_busy", {15'd0, busy}, 16'd0);
        checkOutput("rst_fifo_count", {13'd0, fifo_count}, 16'd0);
        checkOutput("rst_issued", issued_count, 16'd0);
        checkOutput("rst_timeout_err", {15'd0, timeout_err}, 16'd0);
        checkOutput("rst_in_ready", {15'd0, in_ready}, 16'd1);

        // single instruction, done three cycles after run
        seq_enable = 1'b1;
        applyStimulus(16'h1001);
        checkOutput("t1_count_after_push", {13'd0, fifo_count}, 16'd1);
        checkOutput("t1_no_run_yet", {15'd0, proc_run}, 16'd0);
        tick();
        checkOutput("t1_run", {15'd0, proc_run}, 16'd1);
        checkOutput("t1_din", proc_din, 16'h1001);
        checkOutput("t1_busy", {15'd0, busy}, 16'd1);
        checkOutput("t1_fifo_empty", {13'd0, fifo_count}, 16'd0);
        tick();
        checkOutput("t1_run_one_cycle", {15'd0, proc_run}, 16'd0);
        checkOutput("t1_busy_wait", {15'd0, busy}, 16'd1);
        finishWait(1);
        checkOutput("t1_issued", issued_count, 16'd1);
        checkOutput("t1_idle_busy", {15'd0, busy}, 16'd0);
        checkOutput("t1_din_held", proc_din, 16'h1001);

        // three words, issued in order, each only after the previous done
        seq_enable = 1'b0;
        applyStimulus(16'h1001);
        applyStimulus(16'h1202);
        applyStimulus(16'h4001);
        checkOutput("t2_queued", {13'd0, fifo_count}, 16'd3);
        seq_enable = 1'b1;
        serve(2);
        serve(2);
        serve(2);
        checkOutput("t2_issued", issued_count, 16'd4);
        checkOutput("t2_log1", issue_log[1], 16'h1001);
        checkOutput("t2_log2", issue_log[2], 16'h1202);
        checkOutput("t2_log3", issue_log[3], 16'h4001);

        // fill the FIFO while disabled; fifth word held until the first pop
        words[0] = 16'h2003; words[1] = 16'h2104; words[2] = 16'h3205;
        words[3] = 16'h5306; words[4] = 16'h6407;
        seq_enable = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(words[i]);
        in_valid = 1'b1;
        in_data  = words[4];
        tick();
        tick();
        checkOutput("t3_full_count", {13'd0, fifo_count}, 16'd4);
        checkOutput("t3_full_ready", {15'd0, in_ready}, 16'd0);
        checkOutput("t3_no_run", 16'(issue_log.size()), 16'd4);
        seq_enable = 1'b1;
        tick();
        checkOutput("t3_first_run", {15'd0, proc_run}, 16'd1);
        checkOutput("t3_first_din", proc_din, words[0]);
        checkOutput("t3_count_after_pop", {13'd0, fifo_count}, 16'd3);
        tick();
        in_valid = 1'b0;
        checkOutput("t3_fifth_accepted", {13'd0, fifo_count}, 16'd4);
        finishWait(1);
        for (int i = 0; i < 4; i++) serve(1);
        checkOutput("t3_issued", issued_count, 16'd9);
        for (int i = 0; i < 5; i++) checkOutput("t3_order", issue_log[4 + i], words[i]);

        // dropping seq_enable mid-instruction lets it finish but stops further issue
        seq_enable = 1'b0;
        applyStimulus(16'h7008);
        applyStimulus(16'h0109);
        seq_enable = 1'b1;
        tick();
        checkOutput("t4_run", proc_din, 16'h7008);
        tick();
        seq_enable = 1'b0;
        finishWait(2);
        checkOutput("t4_issued", issued_count, 16'd10);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t4_gated_run", {15'd0, proc_run}, 16'd0);
        end
        checkOutput("t4_held_count", {13'd0, fifo_count}, 16'd1);
        seq_enable = 1'b1;
        tick();
        checkOutput("t4_resume_run", {15'd0, proc_run}, 16'd1);
        checkOutput("t4_resume_din", proc_din, 16'h0109);
        tick();
        finishWait(1);
        checkOutput("t4_issued2", issued_count, 16'd11);

        // flush during WAIT_DONE, then flush against a push, then reset mid-instruction
        seq_enable = 1'b0;
        applyStimulus(16'h1111);
        applyStimulus(16'h2222);
        applyStimulus(16'h3333);
        applyStimulus(16'h4444);
        seq_enable = 1'b1;
        tick();
        checkOutput("t5_count_after_issue", {13'd0, fifo_count}, 16'd3);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("t5_flushed", {13'd0, fifo_count}, 16'd0);
        checkOutput("t5_still_busy", {15'd0, busy}, 16'd1);
        finishWait(1);
        checkOutput("t5_inflight_counted", issued_count, 16'd12);
        tick();
        checkOutput("t5_no_run_empty", {15'd0, proc_run}, 16'd0);
        in_valid = 1'b1;
        in_data  = 16'h5555;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("t5_flush_beats_push", {13'd0, fifo_count}, 16'd0);
        tick();
        checkOutput("t5_no_issue_after_flush", {15'd0, proc_run}, 16'd0);
        applyStimulus(16'h6666);
        tick();
        tick();
        checkOutput("t5_busy_before_reset", {15'd0, busy}, 16'd1);
        reset_n = 1'b0;
        #2;
        checkOutput("t5_rst_din", proc_din, 16'h0000);
        checkOutput("t5_rst_busy", {15'd0, busy}, 16'd0);
        checkOutput("t5_rst_issued", issued_count, 16'd0);
        checkOutput("t5_rst_count", {13'd0, fifo_count}, 16'd0);
        checkOutput("t5_rst_ready", {15'd0, in_ready}, 16'd1);
        tick();
        reset_n   = 1'b1;
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        checkOutput("t5_stray_done_ignored", issued_count, 16'd0);

`ifdef SEQ_TIMEOUT_EN
        // withheld done trips the watchdog after eight WAIT_DONE cycles
        applyStimulus(16'h7777);
        tick();
        checkOutput("t6_run", {15'd0, proc_run}, 16'd1);
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput("t6_still_waiting", {14'd0, busy, timeout_err}, 16'd2);
        end
        tick();
        checkOutput("t6_timeout", {15'd0, timeout_err}, 16'd1);
        checkOutput("t6_halt_not_busy", {15'd0, busy}, 16'd0);
        applyStimulus(16'h8888);
        checkOutput("t6_push_in_halt", {13'd0, fifo_count}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t6_no_run_halt", {15'd0, proc_run}, 16'd0);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("t6_err_cleared", {15'd0, timeout_err}, 16'd0);
        checkOutput("t6_flushed", {13'd0, fifo_count}, 16'd0);
        checkOutput("t6_not_counted", issued_count, 16'd0);
        tick();
        checkOutput("t6_idle_no_run", {15'd0, proc_run}, 16'd0);
        checkOutput("t6_log_size", 16'(issue_log.size()), 16'd14);
`else
        checkOutput("t6_err_tied", {15'd0, timeout_err}, 16'd0);
        checkOutput("t6_log_size", 16'(issue_log.size()), 16'd13);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
